video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen_if.sv | 15 +
 rtl/video_timing_gen.sv | 123 ++++++++++++
 tb/tb_video_timing_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: raster enable input plus sync, position, frame and prefetch outputs of the timing generator
interface video_timing_gen_if #(parameter int CW = 12);
  logic en_i;
  logic hsync_o;
  logic vsync_o;
  logic de_o;
  logic sof_o;
  logic eol_o;
  logic fetch_req_o;
  logic running_o;
  logic [CW-1:0] x_o;
  logic [CW-1:0] y_o;
  modport master(input en_i, output hsync_o, vsync_o, de_o, x_o, y_o, sof_o, eol_o, fetch_req_o, running_o);
  modport slave(output en_i, input hsync_o, vsync_o, de_o, x_o, y_o, sof_o, eol_o, fetch_req_o, running_o);
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: registered raster timing generator; define VTG_PREFETCH_EN for the FETCH_LEAD-ahead pixel prefetch strobe
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int CW         = 12,
  parameter int FETCH_LEAD = 2
) (
  input logic clk_i,
  input logic rstn_i,
  video_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef logic [CW-1:0] c_t;
  typedef logic [CW:0] w_t;
  typedef enum logic {IDLE, RUN} state_t;
  localparam c_t X_LAST = c_t'(H_TOTAL - 1);
  localparam c_t Y_LAST = c_t'(V_TOTAL - 1);
  localparam w_t HA = w_t'(H_ACTIVE);
  localparam w_t HA_LAST = w_t'(H_ACTIVE - 1);
  localparam w_t HS0 = w_t'(H_ACTIVE + H_FP);
  localparam w_t HS1 = w_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam w_t HT = w_t'(H_TOTAL);
  localparam w_t VA = w_t'(V_ACTIVE);
  localparam w_t VS0 = w_t'(V_ACTIVE + V_FP);
  localparam w_t VS1 = w_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HP = 1'(HSYNC_POL);
  localparam logic VP = 1'(VSYNC_POL);
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero
    $error("timing parameters must be nonzero");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CW) || longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_cw
    $error("CW too narrow for raster totals");
  end
  if (FETCH_LEAD < 1 || FETCH_LEAD >= H_FP + H_SYNC + H_BP) begin : g_lead
    $error("FETCH_LEAD out of range");
  end
`ifdef VTG_PREFETCH_EN
  localparam c_t X0 = c_t'(H_TOTAL - FETCH_LEAD);
  localparam c_t Y0 = Y_LAST;
`else
  localparam c_t X0 = '0;
  localparam c_t Y0 = '0;
`endif
  state_t state_q, state_d;
  c_t x_q, x_d, y_q, y_d;
  w_t xe, ye;
  logic h_end, v_end, run_d;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d, eol_q, eol_d;
  always_comb begin
    h_end = x_q == X_LAST;
    v_end = y_q == Y_LAST;
    state_d = (state_q == IDLE) ? (vif.en_i ? RUN : IDLE) : ((h_end && v_end && !vif.en_i) ? IDLE : RUN);
    run_d = state_d == RUN;
    x_d = !run_d ? '0 : (state_q == IDLE) ? X0 : h_end ? '0 : x_q + 1'b1;
    y_d = !run_d ? '0 : (state_q == IDLE) ? Y0 : !h_end ? y_q : v_end ? '0 : y_q + 1'b1;
    xe = {1'b0, x_d};
    ye = {1'b0, y_d};
    de_d = run_d && xe < HA && ye < VA;
    hs_d = (run_d && xe >= HS0 && xe < HS1) ? HP : ~HP;
    vs_d = (run_d && ye >= VS0 && ye < VS1) ? VP : ~VP;
    sof_d = run_d && x_d == '0 && y_d == '0;
    eol_d = run_d && xe == HA_LAST && ye < VA;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      de_q <= 1'b0;
      hs_q <= ~HP;
      vs_q <= ~VP;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
    end
  end
  assign vif.running_o = state_q == RUN;
  assign vif.x_o = x_q;
  assign vif.y_o = y_q;
  assign vif.de_o = de_q;
  assign vif.hsync_o = hs_q;
  assign vif.vsync_o = vs_q;
  assign vif.sof_o = sof_q;
  assign vif.eol_o = eol_q;
`ifdef VTG_PREFETCH_EN
  localparam w_t FL = w_t'(FETCH_LEAD);
  w_t xa, xl, yl;
  logic h_wrap, f_wrap, fetch_q, fetch_d;
  always_comb begin
    xa = xe + FL;
    h_wrap = xa >= HT;
    f_wrap = h_wrap && y_d == Y_LAST;
    xl = h_wrap ? xa - HT : xa;
    yl = !h_wrap ? ye : f_wrap ? '0 : ye + 1'b1;
    fetch_d = run_d && xl < HA && yl < VA && (!f_wrap || vif.en_i);
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) fetch_q <= 1'b0;
    else fetch_q <= fetch_d;
  end
  assign vif.fetch_req_o = fetch_q;
`else
  assign vif.fetch_req_o = 1'b0;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of a 7x5 raster (H 4/1/1/1, V 2/1/1/1, HSYNC_POL=1)
module tb_video_timing_gen;
`ifdef VTG_PREFETCH_EN
  localparam int SX = 5, SY = 4;
`else
  localparam int SX = 0, SY = 0;
`endif
  logic clk = 1'b0;
  logic rstn_i = 1'b1;
  int checks = 0, errors = 0;
  int ex = 0, ey = 0;
  bit e = 1'b1;
  always #5 clk = ~clk;
  video_timing_gen_if #(.CW(4)) vif();
  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(0), .CW(4), .FETCH_LEAD(2)
  ) dut (.clk_i(clk), .rstn_i(rstn_i), .vif(vif.master));
  function automatic logic [14:0] obs();
    return {vif.running_o, vif.de_o, vif.hsync_o, vif.vsync_o, vif.sof_o, vif.eol_o, vif.fetch_req_o, vif.x_o, vif.y_o};
  endfunction
  function automatic logic [14:0] exp_vec(int x, int y, bit run, bit f);
    if (!run) return {7'b0001000, 4'd0, 4'd0};
    return {1'b1, x < 4 && y < 2, x == 5, y != 3, x == 0 && y == 0, x == 3 && y < 2, f, 4'(x), 4'(y)};
  endfunction
  function automatic bit fetch_exp(int x, int y, bit en);
`ifdef VTG_PREFETCH_EN
    int p = y * 7 + x + 2;
    bit wrap = p >= 35;
    p = p % 35;
    return (p % 7) < 4 && (p / 7) < 2 && (!wrap || en);
`else
    return 1'b0;
`endif
  endfunction
  task automatic step();
    ex = (ex == 6) ? 0 : ex + 1;
    if (ex == 0) ey = (ey == 4) ? 0 : ey + 1;
  endtask
  task automatic test_reset();
    logic [14:0] got;
    vif.en_i = 1'b0;
    #1 rstn_i = 1'b0;
    #2 got = obs();
    checks++;
    if (got !== exp_vec(0, 0, 0, 0)) begin errors++; $display("FAIL reset_async got %h want %h", got, exp_vec(0, 0, 0, 0)); end
    repeat (2) @(posedge clk);
    @(negedge clk) rstn_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 got = obs();
      checks++;
      if (got !== exp_vec(0, 0, 0, 0)) begin errors++; $display("FAIL idle_hold cycle %0d got %h want %h", i, got, exp_vec(0, 0, 0, 0)); end
    end
  endtask
  task automatic test_frame();
    logic [14:0] got, want;
    int w = 0, n_de = 0, n_hs = 0, n_vs = 0, n_sof = 0, n_eol = 0, n_f = 0;
    bit on = 1'b0;
    vif.en_i = 1'b1;
    @(posedge clk); #1;
    ex = SX; ey = SY;
    for (int i = 0; i < 45; i++) begin
      got = obs();
      want = exp_vec(ex, ey, 1, fetch_exp(ex, ey, 1));
      checks++;
      if (got !== want) begin errors++; $display("FAIL frame x=%0d y=%0d got %h want %h", ex, ey, got, want); end
      if (ex == 0 && ey == 0) on = 1'b1;
      if (on && w < 35) begin
        w++; n_de += int'(got[13]); n_hs += int'(got[12]); n_vs += int'(!got[11]);
        n_sof += int'(got[10]); n_eol += int'(got[9]); n_f += int'(got[8]);
      end
      step();
      @(posedge clk); #1;
    end
    checks++; if (n_de !== 8) begin errors++; $display("FAIL de_count got %0d want 8", n_de); end
    checks++; if (n_hs !== 5) begin errors++; $display("FAIL hsync_count got %0d want 5", n_hs); end
    checks++; if (n_vs !== 7) begin errors++; $display("FAIL vsync_count got %0d want 7", n_vs); end
    checks++; if (n_sof !== 1) begin errors++; $display("FAIL sof_count got %0d want 1", n_sof); end
    checks++; if (n_eol !== 2) begin errors++; $display("FAIL eol_count got %0d want 2", n_eol); end
`ifdef VTG_PREFETCH_EN
    checks++; if (n_f !== 8) begin errors++; $display("FAIL fetch_count got %0d want 8", n_f); end
`else
    checks++; if (n_f !== 0) begin errors++; $display("FAIL fetch_count got %0d want 0", n_f); end
`endif
  endtask
  task automatic test_en_drop();
    logic [14:0] got, want;
    int idx, n = 0;
    got = obs();
    want = exp_vec(ex, ey, 1, fetch_exp(ex, ey, 1));
    checks++;
    if (got !== want) begin errors++; $display("FAIL drop_start got %h want %h", got, want); end
    idx = ey * 7 + ex;
    vif.en_i = 1'b0;
    while (!(ex == 6 && ey == 4) && n < 40) begin
      e = vif.en_i;
      @(posedge clk); #1;
      step(); n++;
      got = obs();
      want = exp_vec(ex, ey, 1, fetch_exp(ex, ey, e));
      checks++;
      if (got !== want) begin errors++; $display("FAIL drop_run x=%0d y=%0d got %h want %h", ex, ey, got, want); end
      if (n == 10) vif.en_i = 1'b1;
      if (n == 12) vif.en_i = 1'b0;
    end
    checks++;
    if (n !== 34 - idx) begin errors++; $display("FAIL drop_length got %0d want %0d", n, 34 - idx); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 got = obs();
      checks++;
      if (got !== exp_vec(0, 0, 0, 0)) begin errors++; $display("FAIL drop_idle cycle %0d got %h want %h", i, got, exp_vec(0, 0, 0, 0)); end
    end
  endtask
  task automatic test_back_to_back();
    logic [14:0] got, want;
    int steps = ((35 - (SY * 7 + SX)) % 35) + 38;
    vif.en_i = 1'b1;
    e = 1'b1;
    @(posedge clk); #1;
    ex = SX; ey = SY;
    for (int i = 0; i < steps; i++) begin
      got = obs();
      want = exp_vec(ex, ey, 1, fetch_exp(ex, ey, e));
      checks++;
      if (got !== want) begin errors++; $display("FAIL b2b x=%0d y=%0d got %h want %h", ex, ey, got, want); end
      if (ex == 0 && ey == 2) vif.en_i = 1'b0;
      if (ex == 3 && ey == 4) vif.en_i = 1'b1;
      e = vif.en_i;
      step();
      @(posedge clk); #1;
    end
  endtask
  task automatic test_async_reset();
    logic [14:0] got, want;
    #2 rstn_i = 1'b0;
    #1 got = obs();
    checks++;
    if (got !== exp_vec(0, 0, 0, 0)) begin errors++; $display("FAIL rst_mid got %h want %h", got, exp_vec(0, 0, 0, 0)); end
    @(negedge clk) rstn_i = 1'b1;
    @(posedge clk); #1;
    ex = SX; ey = SY;
    for (int i = 0; i < 3; i++) begin
      got = obs();
      want = exp_vec(ex, ey, 1, fetch_exp(ex, ey, 1));
      checks++;
      if (got !== want) begin errors++; $display("FAIL rst_rerun x=%0d y=%0d got %h want %h", ex, ey, got, want); end
      step();
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_frame();
    test_en_drop();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
